// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encoding and divisor helpers
// Contents:
//   UART_DATA_BITS  data bits per frame (8)
//   UART_DIV_W      width of the clocks-per-bit divisor (18)
//   UART_MIN_DIV    smallest supported divisor (4)
//   UART_IDX_W      width of the data-bit index
//   uart_state_e    FSM encoding shared by the RX and TX sides
//   uart_div_t      divisor / bit-counter type
//   uart_half_bit   half-bit sample point H = (N-1)>>1

package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_W     = 18;
  localparam int UART_MIN_DIV   = 4;
  localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

  // Values must stay identical to the transmitter's encoding.
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_START   = 3'b001,
    S_DATA    = 3'b010,
    S_STOP    = 3'b011,
    S_CLEANUP = 3'b100
  } uart_state_e;

  typedef logic [UART_DIV_W-1:0] uart_div_t;

  // Count value at which the start bit is re-checked: the middle of the bit.
  function automatic uart_div_t uart_half_bit(input uart_div_t n);
    return (n - uart_div_t'(1)) >> 1;
  endfunction

  // Last count value of a full bit period.
  function automatic uart_div_t uart_full_bit(input uart_div_t n);
    return n - uart_div_t'(1);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for an asynchronous single-bit input
// Ports:
//   internal_clock  in   destination clock
//   reset           in   synchronous, active-high; loads RESET_VAL into both stages
//   async_bit       in   asynchronous input
//   sync_bit        out  synchronized copy, two clocks of latency
// Parameters:
//   RESET_VAL       value held in both stages during reset (idle level of the line)

module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic internal_clock,
  input  logic reset,
  input  logic async_bit,
  output logic sync_bit
);

  logic meta;

  always_ff @(posedge internal_clock) begin
    if (reset) begin
      meta     <= RESET_VAL;
      sync_bit <= RESET_VAL;
    end else begin
      meta     <= async_bit;
      sync_bit <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, LSB first, runtime clocks-per-bit, mid-bit sampling
// Ports:
//   internal_clock  in   sole clock, rising edge
//   reset           in   synchronous, active-high
//   CLK_PERS_BIT    in   clocks per bit N, latched at frame start (N >= 4)
//   Rx_Serial       in   asynchronous serial line, idle high
//   Rx_Byte         out  received byte, updated with Rx_Done and held until the next one
//   Rx_Done         out  one-cycle strobe per completed frame
//   Rx_Active       out  high from start-bit confirmation until Rx_Done
//   Rx_Frame_Err    out  stop bit was low; qualifies Rx_Done (only with UART_RX_FRAME_CHECK_EN)
// Build option:
//   UART_RX_FRAME_CHECK_EN  adds Rx_Frame_Err; otherwise the stop bit is not checked

module uart_receiver
  import uart_pkg::*;
(
  input  logic                      internal_clock,
  input  logic                      reset,
  input  logic [UART_DIV_W-1:0]     CLK_PERS_BIT,
  input  logic                      Rx_Serial,
  output logic [UART_DATA_BITS-1:0] Rx_Byte,
  output logic                      Rx_Done,
  output logic                      Rx_Active
`ifdef UART_RX_FRAME_CHECK_EN
  ,
  output logic                      Rx_Frame_Err
`endif
);

  localparam int DATA_BITS = UART_DATA_BITS;
  localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(DATA_BITS - 1);
  localparam uart_div_t MIN_DIV = UART_DIV_W'(UART_MIN_DIV);

  logic                  rx_s;
  uart_state_e           state;
  uart_div_t             cnt;
  uart_div_t             n_lat;
  uart_div_t             half_cnt;
  uart_div_t             last_cnt;
  logic [UART_IDX_W-1:0] idx;
  logic [DATA_BITS-1:0]  shift;
`ifdef UART_RX_FRAME_CHECK_EN
  logic                  stop_ok;
`endif

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .internal_clock (internal_clock),
    .reset          (reset),
    .async_bit      (Rx_Serial),
    .sync_bit       (rx_s)
  );

  // Both thresholds derive from the divisor latched at frame start, so
  // changes on CLK_PERS_BIT mid-frame cannot disturb the frame in flight.
  assign half_cnt = uart_half_bit(n_lat);
  assign last_cnt = uart_full_bit(n_lat);

  always_ff @(posedge internal_clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      n_lat     <= MIN_DIV;
      shift     <= '0;
      Rx_Byte   <= '0;
      Rx_Done   <= 1'b0;
      Rx_Active <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
      stop_ok      <= 1'b1;
      Rx_Frame_Err <= 1'b0;
`endif
    end else begin
      Rx_Done <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          idx <= '0;
          // Divisors below the minimum would leave no room for a half-bit
          // check, so such a setting simply never leaves IDLE.
          if (!rx_s && (CLK_PERS_BIT >= MIN_DIV)) begin
            n_lat <= CLK_PERS_BIT;
            state <= S_START;
          end
        end

        S_START: begin
          if (cnt < half_cnt) begin
            cnt <= cnt + uart_div_t'(1);
          end else begin
            cnt <= '0;
            // Line still low at mid start bit: a real frame. Otherwise a glitch.
            if (!rx_s) begin
              Rx_Active <= 1'b1;
              state     <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_DATA: begin
          // Counting a full period from the mid start bit lands on mid data bit.
          if (cnt < last_cnt) begin
            cnt <= cnt + uart_div_t'(1);
          end else begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            if (idx < LAST_IDX) begin
              idx <= idx + 1'b1;
            end else begin
              idx   <= '0;
              state <= S_STOP;
            end
          end
        end

        S_STOP: begin
          // Leaves at mid stop bit so IDLE is reached before a back-to-back
          // frame's start edge arrives.
          if (cnt < last_cnt) begin
            cnt <= cnt + uart_div_t'(1);
          end else begin
            cnt <= '0;
`ifdef UART_RX_FRAME_CHECK_EN
            stop_ok <= rx_s;
`endif
            state <= S_CLEANUP;
          end
        end

        S_CLEANUP: begin
          Rx_Byte   <= shift;
          Rx_Done   <= 1'b1;
          Rx_Active <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
          Rx_Frame_Err <= ~stop_ok;
`endif
          state <= S_IDLE;
        end

        default: begin
          cnt   <= '0;
          idx   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
